// File: rtl/wb_io_decode_mux256.sv
// -----------------------------------------------------------------------------
// wb_io_decode_mux256
//   Address decoder / response mux sitting behind the 256-bit I/O bridge.
//   One bridge request is steered to the first matching peripheral port. The
//   single response channel carries, in priority order:
//     1. transaction responses (device ack, decode error, timeout),
//     2. device MSI responses (err == IRQ), each buffered in a one-deep
//        per-device slot and emitted lowest index first.
//   Every output is registered.
//
// Ports
//   clk_i, rst_ni   clock, async active-low reset
//   s_req           request from the bridge master port
//   s_resp          response to the bridge channel (one-cycle pulses)
//   dev_req[]       per-device requests (idle: all zero, adr = FFFF_FFFF)
//   dev_resp[]      per-device responses
//   irq_drop        one-cycle pulse when an MSI hits an occupied slot
// -----------------------------------------------------------------------------
package wishbone_pkg;
  typedef enum logic [1:0] {OK = 2'd0, ERR = 2'd1, DECERR = 2'd2, IRQ = 2'd3} wb_err_e;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [31:0]  sel;
    logic [31:0]  adr;
    logic [255:0] dat;
    logic [7:0]   tid;
    logic [2:0]   cti;
    logic [1:0]   bte;
    logic [3:0]   cmd;
  } wb_cmd_request256_t;

  typedef struct packed {
    logic         ack;
    logic         stall;
    wb_err_e      err;
    logic [7:0]   tid;
    logic [255:0] dat;
  } wb_cmd_response256_t;
endpackage

// One-entry MSI holding slot for a single device. A pop and a new IRQ on the
// same cycle refill the slot rather than dropping the newcomer.
module wb_io_irq_slot
  import wishbone_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  wb_cmd_response256_t resp,
  input  logic                pop,
  output logic                pend,
  output wb_cmd_response256_t held,
  output logic                drop
);
  logic irq_in;

  assign irq_in = resp.ack && (resp.err == IRQ);
  assign drop   = irq_in && pend && !pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend <= 1'b0;
      held <= '0;
    end else if (irq_in && (!pend || pop)) begin
      pend <= 1'b1;
      held <= resp;
    end else if (pop) begin
      pend <= 1'b0;
    end
  end
endmodule

module wb_io_decode_mux256
  import wishbone_pkg::*;
#(
  parameter int                         DEVICES     = 4,
  parameter logic [0:DEVICES-1][31:0]   DEV_BASE    = {32'hFEE00000, 32'hFEE10000,
                                                       32'hFEE20000, 32'hFEE30000},
  parameter logic [0:DEVICES-1][31:0]   DEV_MASK    = {DEVICES{32'hFFFF0000}},
  parameter int                         TIMEOUT     = 255,
  parameter wb_err_e                    DECERR_CODE = DECERR,
  parameter wb_err_e                    TOERR_CODE  = ERR
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  wb_cmd_request256_t                   s_req,
  output wb_cmd_response256_t                  s_resp,
  output wb_cmd_request256_t  [DEVICES-1:0]    dev_req,
  input  wb_cmd_response256_t [DEVICES-1:0]    dev_resp,
  output logic                                 irq_drop
);
  localparam int SEL_W = (DEVICES > 1) ? $clog2(DEVICES) : 1;
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT);
  localparam wb_cmd_request256_t REQ_IDLE = '{cyc: 1'b0, stb: 1'b0, we: 1'b0,
                                              sel: 32'h0, adr: 32'hFFFF_FFFF,
                                              dat: 256'h0, tid: 8'h0, cti: 3'h0,
                                              bte: 2'h0, cmd: 4'h0};

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WAIT_END} state_e;

  state_e                             state_q, state_n;
  logic [SEL_W-1:0]                   sel_q, sel_n;
  logic [9:0]                         timer_q, timer_n;
  logic [7:0]                         tid_q, tid_n;
  wb_cmd_response256_t                s_resp_n;
  wb_cmd_request256_t  [DEVICES-1:0]  dev_req_n;

  logic [DEVICES-1:0]                 hit, pend, pop, drop;
  wb_cmd_response256_t [DEVICES-1:0]  irq_buf;
  logic                               hit_any, irq_any;
  logic [SEL_W-1:0]                   hit_idx, irq_idx;

  for (genvar g = 0; g < DEVICES; g++) begin : g_dev
    assign hit[g] = ((s_req.adr & DEV_MASK[g]) == DEV_BASE[g]);

    wb_io_irq_slot u_slot (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .resp   (dev_resp[g]),
      .pop    (pop[g]),
      .pend   (pend[g]),
      .held   (irq_buf[g]),
      .drop   (drop[g])
    );
  end

  // Lowest index wins for both decode and MSI presentation: scan downward so
  // the last match written is the smallest index.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    irq_any = 1'b0;
    irq_idx = '0;
    for (int i = DEVICES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = SEL_W'(i);
      end
      if (pend[i]) begin
        irq_any = 1'b1;
        irq_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    sel_n     = sel_q;
    timer_n   = timer_q;
    tid_n     = tid_q;
    s_resp_n  = '0;
    dev_req_n = {DEVICES{REQ_IDLE}};
    pop       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (s_req.cyc && s_req.stb) begin
          if (hit_any) begin
            sel_n              = hit_idx;
            timer_n            = '0;
            tid_n              = s_req.tid;
            dev_req_n[hit_idx] = s_req;
            state_n            = S_ACTIVE;
          end else begin
            s_resp_n.ack = 1'b1;
            s_resp_n.err = DECERR_CODE;
            s_resp_n.tid = s_req.tid;
            state_n      = S_WAIT_END;
          end
        end
      end
      S_ACTIVE: begin
        // Master abort: release the device silently.
        if (!s_req.cyc) begin
          state_n = S_IDLE;
        end else if (dev_resp[sel_q].ack && (dev_resp[sel_q].err != IRQ)) begin
          s_resp_n = dev_resp[sel_q];
          state_n  = S_WAIT_END;
        end else if ((timer_q + 10'd1) == TO_LAST) begin
          s_resp_n.ack = 1'b1;
          s_resp_n.err = TOERR_CODE;
          s_resp_n.tid = tid_q;
          state_n      = S_WAIT_END;
        end else begin
          timer_n          = timer_q + 10'd1;
          dev_req_n[sel_q] = s_req;
          s_resp_n.stall   = dev_resp[sel_q].stall;
        end
      end
      S_WAIT_END: begin
        if (!s_req.cyc) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // MSIs only fill otherwise-empty response slots.
    if ((s_resp_n == '0) && irq_any) begin
      s_resp_n     = irq_buf[irq_idx];
      pop[irq_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      timer_q  <= '0;
      tid_q    <= '0;
      s_resp   <= '0;
      dev_req  <= {DEVICES{REQ_IDLE}};
      irq_drop <= 1'b0;
    end else begin
      state_q  <= state_n;
      sel_q    <= sel_n;
      timer_q  <= timer_n;
      tid_q    <= tid_n;
      s_resp   <= s_resp_n;
      dev_req  <= dev_req_n;
      irq_drop <= |drop;
    end
  end
endmodule
